hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  pipeline clock; reset  in  1  synchronous, active-high reset, sampled on rising CLK.
REQ-002 SHALL have inputs: rs1D, rs2D  in  5  decode source registers; rs1E, rs2E, rdE  in  5  execute-stage registers (low 5 bits of the ID/EX fields).
REQ-003 SHALL have inputs: ResultSrcE  in  2  (2'b01 = load); regWriteE  in  1; PCSrcE  in  1  branch/jump taken in EX.
REQ-004 SHALL have inputs: rdM, rdW  in  5; regWriteM, regWriteW  in  1; memReqM  in  1  data-memory request; memReadyM  in  1  data-memory done.
REQ-005 SHALL have outputs, 1 bit each: stallF, stallD, stallE, stallM, flushD, flushE, flushW.
REQ-006 SHALL have outputs: forwardAE, forwardBE  out  2  (00 = register file, 01 = WB result, 10 = MEM ALU result).

Function
REQ-007 SHALL implement a registered FSM with states INIT, RUN, MEMWAIT; all other outputs are combinational from state and inputs.
REQ-008 INIT SHALL drive flushD=flushE=1, stallF=1, all other stall/flush outputs 0; INIT->RUN unconditionally on the next edge.
REQ-009 RUN SHALL compute lwStall = (ResultSrcE==2'b01) & (rdE!=0) & ((rdE==rs1D)|(rdE==rs2D)).
REQ-010 RUN SHALL drive stallF=stallD=lwStall, flushD=PCSrcE, flushE=lwStall|PCSrcE, stallE=stallM=flushW=0.
REQ-011 RUN->MEMWAIT SHALL occur when memReqM=1 and memReadyM=0; in that cycle stallF, stallD, stallE, stallM and flushW SHALL be 1 and flushD=flushE=0 (memory stall overrides lwStall and PCSrcE).
REQ-012 MEMWAIT SHALL drive stallF=stallD=stallE=stallM=flushW=1 and flushD=flushE=0; MEMWAIT->RUN when memReadyM=1, with that cycle's outputs still those of MEMWAIT.
REQ-013 A branch taken while the memory stall is active SHALL be held in EX by stallE and flushed in the first RUN cycle afterwards; no flush is lost or duplicated.
REQ-014 memReqM=1 with memReadyM=1 in RUN SHALL NOT stall (zero-wait access).
REQ-015 forwardAE SHALL be 10 if regWriteM & rdM!=0 & rdM==rs1E; else 01 if regWriteW & rdW!=0 & rdW==rs1E; else 00. The MEM stage has priority over WB.
REQ-016 forwardBE SHALL follow REQ-015 with rs2E substituted for rs1E.
REQ-017 Forwarding SHALL be combinational in every state; register x0 SHALL never be forwarded.

Reset
REQ-018 reset=1 at a rising edge SHALL force state to INIT, from any state including MEMWAIT.
REQ-019 While state is INIT, outputs SHALL be: flushD=flushE=stallF=1; stallD=stallE=stallM=flushW=0; forward outputs per REQ-015/016.
REQ-020 An outstanding memory wait SHALL be abandoned by reset; after reset the FSM does not return to MEMWAIT unless REQ-011 holds again.

Configuration
REQ-021 Macro HAZARD_PERF_COUNTERS_EN SHALL add outputs stallCycles and flushCount, each 32 bits.
REQ-022 With the macro defined: stallCycles SHALL increment each cycle in which stallF=1 in RUN or MEMWAIT. flushCount SHALL increment each RUN cycle in which PCSrcE=1 and REQ-011 does not apply. Both SHALL saturate at 32'hFFFFFFFF and reset to 0.
REQ-023 Without the macro, these ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-024 Reset held 2 cycles, then released -> 1 cycle of flushD=flushE=stallF=1, then RUN with all stalls 0.
REQ-025 Load in EX with ResultSrcE=01, rdE=5, rs1D=5 -> stallF=stallD=flushE=1 for 1 cycle. The same case with rdE=0 -> no stall.
REQ-026 rdM=rdW=7, regWriteM=regWriteW=1, rs1E=7, rs2E=7 -> forwardAE=forwardBE=10. With regWriteM=0 -> 01. With rs1E=0 -> forwardAE=00.
REQ-027 memReqM=1 and memReadyM=0 for 3 cycles, then memReadyM=1 -> stallF/D/E/M=flushW=1 for 4 cycles, then RUN.
REQ-028 PCSrcE=1 asserted during a memory wait and held -> no flush during the wait; flushD=flushE=1 in the first RUN cycle. With the macro defined, flushCount=1.
REQ-029 reset=1 in the middle of MEMWAIT -> next state INIT; memReadyM arriving later causes no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory wait stall and operand forwarding.
// Optional performance counters (stallCycles, flushCount) are built when HAZARD_PERF_COUNTERS_EN is defined.
module hazard_ctrl (
  input  logic       CLK,
  input  logic       reset,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  input  logic [4:0] rdE,
  input  logic [1:0] ResultSrcE,
  input  logic       regWriteE,
  input  logic       PCSrcE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  input  logic       memReqM,
  input  logic       memReadyM,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushW,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
`ifdef HAZARD_PERF_COUNTERS_EN
  output logic [31:0] stallCycles,
  output logic [31:0] flushCount,
`endif
  output logic [1:0] state_dbg
);

  // Handshake: a data-memory access is pending while memReqM=1 and completes
  // in the cycle memReadyM=1; the pipeline is frozen until that cycle ends.
  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   lw_stall;
  logic   mem_stall;

  // regWriteE is part of the stage interface but not needed for these decisions.
  logic unused_ok;
  assign unused_ok = regWriteE;

  assign state_dbg = state;
  assign mem_stall = memReqM & ~memReadyM;
  assign lw_stall  = (ResultSrcE == 2'b01) && (rdE != 5'd0) &&
                     ((rdE == rs1D) || (rdE == rs2D));

  always_ff @(posedge CLK) begin
    if (reset) state <= S_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushW     = 1'b0;
    case (state)
      S_INIT: begin
        stallF     = 1'b1;
        flushD     = 1'b1;
        flushE     = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (mem_stall) begin
          // Memory wait freezes everything; a taken branch stays held in EX.
          stallF     = 1'b1;
          stallD     = 1'b1;
          stallE     = 1'b1;
          stallM     = 1'b1;
          flushW     = 1'b1;
          state_next = S_MEMWAIT;
        end else begin
          stallF = lw_stall;
          stallD = lw_stall;
          flushD = PCSrcE;
          flushE = lw_stall | PCSrcE;
        end
      end
      S_MEMWAIT: begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
        if (memReadyM) state_next = S_RUN;
      end
      default: state_next = S_INIT;
    endcase
  end

  always_comb begin
    forwardAE = 2'b00;
    if (regWriteM && (rdM != 5'd0) && (rdM == rs1E))      forwardAE = 2'b10;
    else if (regWriteW && (rdW != 5'd0) && (rdW == rs1E)) forwardAE = 2'b01;
  end

  always_comb begin
    forwardBE = 2'b00;
    if (regWriteM && (rdM != 5'd0) && (rdM == rs2E))      forwardBE = 2'b10;
    else if (regWriteW && (rdW != 5'd0) && (rdW == rs2E)) forwardBE = 2'b01;
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      stallCycles <= 32'd0;
      flushCount  <= 32'd0;
    end else begin
      if (stallF && (state != S_INIT) && (stallCycles != 32'hFFFF_FFFF))
        stallCycles <= stallCycles + 32'd1;
      if ((state == S_RUN) && PCSrcE && !mem_stall && (flushCount != 32'hFFFF_FFFF))
        flushCount <= flushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Also checks the counters when built with HAZARD_PERF_COUNTERS_EN.
module tb_hazard_ctrl;

  logic       CLK;
  logic       reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0] ResultSrcE;
  logic       regWriteE, PCSrcE, regWriteM, regWriteW, memReqM, memReadyM;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [1:0] forwardAE, forwardBE;
  logic [1:0] state_dbg;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stallCycles, flushCount;
`endif

  int errors = 0;
  int checks = 0;

  // Model state: "just reset" and "memory wait outstanding", plus counters.
  bit          m_init = 1'b1;
  bit          m_wait = 1'b0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
  logic [10:0] exp_q[$];

  wire [10:0] dut_vec = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, forwardAE, forwardBE};

  hazard_ctrl dut (
    .CLK(CLK), .reset(reset),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .ResultSrcE(ResultSrcE), .regWriteE(regWriteE), .PCSrcE(PCSrcE),
    .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memReqM(memReqM), .memReadyM(memReadyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
`ifdef HAZARD_PERF_COUNTERS_EN
    .stallCycles(stallCycles), .flushCount(flushCount),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (regWriteM && rdM != 5'd0 && rdM == rs) return 2'b10;
    if (regWriteW && rdW != 5'd0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] model_out();
    logic [6:0] ctl;
    logic       lw;
    lw = (ResultSrcE == 2'b01) && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
    if (m_init)                                ctl = 7'b1000110;
    else if (m_wait || (memReqM && !memReadyM)) ctl = 7'b1111001;
    else ctl = {lw, lw, 1'b0, 1'b0, PCSrcE, lw | PCSrcE, 1'b0};
    return {ctl, fwd(rs1E), fwd(rs2E)};
  endfunction

  // Driver tasks
  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    ResultSrcE = 0; regWriteE = 0; PCSrcE = 0; regWriteM = 0; regWriteW = 0;
    memReqM = 0; memReadyM = 0;
  endtask

  // One clock edge: model follows the rules using the inputs present at the edge.
  task automatic advance();
    logic [10:0] e;
    @(posedge CLK);
    e = model_out();
    if (reset) begin
      m_init = 1'b1; m_wait = 1'b0; m_stall = 32'd0; m_flush = 32'd0;
    end else begin
      if (!m_init && e[10] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (!m_init && !m_wait && PCSrcE && !(memReqM && !memReadyM) && m_flush != 32'hFFFF_FFFF)
        m_flush = m_flush + 32'd1;
      if (m_init)      m_init = 1'b0;
      else if (m_wait) m_wait = !memReadyM;
      else             m_wait = memReqM && !memReadyM;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
    @(negedge CLK);
    checks++;
    if (dut_vec !== 11'b1000110_0000) begin
      errors++; $display("FAIL reset_init got %b want %b", dut_vec, 11'b1000110_0000);
    end
    advance();
    @(negedge CLK);
    checks++;
    if (dut_vec !== 11'b0) begin
      errors++; $display("FAIL reset_run got %b want %b", dut_vec, 11'b0);
    end
    advance();
  endtask

  task automatic test_load_use();
    idle();
    ResultSrcE = 2'b01; rdE = 5'd5; rs1D = 5'd5;
    @(negedge CLK);
    checks++;
    if (dut_vec[10:4] !== 7'b1100010) begin
      errors++; $display("FAIL load_use got %b want %b", dut_vec[10:4], 7'b1100010);
    end
    advance();
    rdE = 5'd0; rs1D = 5'd0;
    @(negedge CLK);
    checks++;
    if (dut_vec[10:4] !== 7'b0) begin
      errors++; $display("FAIL load_use_x0 got %b want %b", dut_vec[10:4], 7'b0);
    end
    advance();
  endtask

  task automatic test_forwarding();
    idle();
    rdM = 5'd7; rdW = 5'd7; regWriteM = 1; regWriteW = 1; rs1E = 5'd7; rs2E = 5'd7;
    @(negedge CLK);
    checks++;
    if (dut_vec[3:0] !== 4'b1010) begin
      errors++; $display("FAIL fwd_mem got %b want %b", dut_vec[3:0], 4'b1010);
    end
    advance();
    regWriteM = 0;
    @(negedge CLK);
    checks++;
    if (dut_vec[3:0] !== 4'b0101) begin
      errors++; $display("FAIL fwd_wb got %b want %b", dut_vec[3:0], 4'b0101);
    end
    advance();
    rs1E = 5'd0;
    @(negedge CLK);
    checks++;
    if (dut_vec[3:0] !== 4'b0001) begin
      errors++; $display("FAIL fwd_x0 got %b want %b", dut_vec[3:0], 4'b0001);
    end
    advance();
  endtask

  task automatic test_mem_wait();
    idle();
    memReqM = 1;
    for (int i = 0; i < 4; i++) begin
      memReadyM = (i == 3);
      @(negedge CLK);
      checks++;
      if (dut_vec[10:4] !== 7'b1111001) begin
        errors++; $display("FAIL mem_wait_%0d got %b want %b", i, dut_vec[10:4], 7'b1111001);
      end
      advance();
    end
    memReqM = 0; memReadyM = 0;
    @(negedge CLK);
    checks++;
    if (dut_vec[10:4] !== 7'b0) begin
      errors++; $display("FAIL mem_wait_exit got %b want %b", dut_vec[10:4], 7'b0);
    end
    advance();
  endtask

  task automatic test_branch_in_wait();
    idle();
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
    advance();
    memReqM = 1; PCSrcE = 1;
    for (int i = 0; i < 4; i++) begin
      memReadyM = (i == 3);
      @(negedge CLK);
      checks++;
      if (dut_vec[6:5] !== 2'b00 || dut_vec[8] !== 1'b1) begin
        errors++; $display("FAIL branch_wait_%0d got %b want stallE=1 flushD/E=00", i, dut_vec[10:4]);
      end
      advance();
    end
    memReqM = 0; memReadyM = 0;
    @(negedge CLK);
    checks++;
    if (dut_vec[10:4] !== 7'b0000110) begin
      errors++; $display("FAIL branch_flush got %b want %b", dut_vec[10:4], 7'b0000110);
    end
    advance();
    PCSrcE = 0;
    @(negedge CLK);
    checks++;
    if (dut_vec[10:4] !== 7'b0) begin
      errors++; $display("FAIL branch_once got %b want %b", dut_vec[10:4], 7'b0);
    end
`ifdef HAZARD_PERF_COUNTERS_EN
    checks++;
    if (flushCount !== 32'd1) begin
      errors++; $display("FAIL flush_count got %0d want 1", flushCount);
    end
    checks++;
    if (stallCycles !== 32'd4) begin
      errors++; $display("FAIL stall_cycles got %0d want 4", stallCycles);
    end
`endif
    advance();
  endtask

  task automatic test_reset_in_wait();
    idle();
    memReqM = 1;
    advance();
    advance();
    reset = 1'b1;
    @(negedge CLK);
    checks++;
    if (dut_vec[10:4] !== 7'b1111001) begin
      errors++; $display("FAIL rst_wait_pre got %b want %b", dut_vec[10:4], 7'b1111001);
    end
    advance();
    reset = 1'b0; memReqM = 0;
    @(negedge CLK);
    checks++;
    if (dut_vec[10:4] !== 7'b1000110) begin
      errors++; $display("FAIL rst_wait_init got %b want %b", dut_vec[10:4], 7'b1000110);
    end
    advance();
    memReadyM = 1;
    @(negedge CLK);
    checks++;
    if (dut_vec[10:4] !== 7'b0) begin
      errors++; $display("FAIL rst_wait_after got %b want %b", dut_vec[10:4], 7'b0);
    end
    advance();
    idle();
  endtask

  task automatic test_random();
    logic [10:0] e;
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 39) == 0);
      rs1D       = 5'($urandom_range(0, 7));
      rs2D       = 5'($urandom_range(0, 7));
      rs1E       = 5'($urandom_range(0, 7));
      rs2E       = 5'($urandom_range(0, 7));
      rdE        = 5'($urandom_range(0, 7));
      rdM        = 5'($urandom_range(0, 7));
      rdW        = 5'($urandom_range(0, 7));
      ResultSrcE = 2'($urandom_range(0, 3));
      regWriteE  = 1'($urandom_range(0, 1));
      regWriteM  = 1'($urandom_range(0, 1));
      regWriteW  = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      memReqM    = ($urandom_range(0, 2) == 0);
      memReadyM  = 1'($urandom_range(0, 1));
      exp_q.push_back(model_out());
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL random_%0d got %b want %b", n, dut_vec, e);
      end
`ifdef HAZARD_PERF_COUNTERS_EN
      checks++;
      if (stallCycles !== m_stall || flushCount !== m_flush) begin
        errors++;
        $display("FAIL random_cnt_%0d got %0d/%0d want %0d/%0d", n, stallCycles, flushCount, m_stall, m_flush);
      end
`endif
      advance();
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_forwarding();
    test_mem_wait();
    test_branch_in_wait();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
